// File: rtl/alu_system.sv
// Small datapath: 8-register file, address register file, 16-bit IR, 256x8 memory
// and an 8-bit ALU with a {Z,C,N,O} flag register, all on one rising-edge clock.
module alu_system (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  RF_OutASel,
  input  logic [2:0]  RF_OutBSel,
  input  logic [1:0]  RF_FunSel,
  input  logic [3:0]  RF_RSel,
  input  logic [3:0]  RF_TSel,
  input  logic [1:0]  ARF_OutCSel,
  input  logic [1:0]  ARF_OutDSel,
  input  logic [1:0]  ARF_FunSel,
  input  logic [3:0]  ARF_RegSel,
  input  logic        IR_LH,
  input  logic        IR_Enable,
  input  logic [1:0]  IR_Funsel,
  input  logic [3:0]  ALU_FunSel,
  input  logic        Mem_WR,
  input  logic        Mem_CS,
  input  logic [1:0]  MuxASel,
  input  logic [1:0]  MuxBSel,
  input  logic        MuxCSel,
  output logic [7:0]  AOut,
  output logic [7:0]  BOut,
  output logic [7:0]  ALUOut,
  output logic [7:0]  ARF_AOut,
  output logic [7:0]  Address,
  output logic [7:0]  MemoryOut,
  output logic [7:0]  MuxAOut,
  output logic [7:0]  MuxBOut,
  output logic [7:0]  MuxCOut,
  output logic [3:0]  ALUOutFlag,
  output logic [15:0] IROut
);

  logic [7:0]  r1_q, r2_q, r3_q, r4_q, t1_q, t2_q, t3_q, t4_q;
  logic [7:0]  pc_q, ar_q, sp_q, pcpast_q;
  logic [15:0] ir_q;
  logic [3:0]  flag_q, flag_d;
  logic [7:0]  mem [256];
  logic [7:0]  rf_view [8];
  logic [7:0]  arf_view [4];
  logic [7:0]  alu_a, alu_b, alu_res;
  logic [8:0]  sum9;
  logic        mem_rd, mem_wr;

  function automatic logic [7:0] fun8(input logic [1:0] sel, input logic [7:0] cur,
                                      input logic [7:0] din);
    case (sel)
      2'b00:   return cur - 8'd1;
      2'b01:   return cur + 8'd1;
      2'b10:   return din;
      default: return 8'd0;
    endcase
  endfunction

  // Select codes index these views directly: T1..T4 then R1..R4; AR, SP, PCpast, PC.
  assign rf_view  = '{t1_q, t2_q, t3_q, t4_q, r1_q, r2_q, r3_q, r4_q};
  assign arf_view = '{ar_q, sp_q, pcpast_q, pc_q};

  assign AOut     = rf_view[RF_OutASel];
  assign BOut     = rf_view[RF_OutBSel];
  assign ARF_AOut = arf_view[ARF_OutCSel];
  assign Address  = arf_view[ARF_OutDSel];
  assign IROut    = ir_q;
  assign ALUOutFlag = flag_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r1_q <= '0; r2_q <= '0; r3_q <= '0; r4_q <= '0;
      t1_q <= '0; t2_q <= '0; t3_q <= '0; t4_q <= '0;
    end else begin
      if (RF_RSel[3]) r1_q <= fun8(RF_FunSel, r1_q, MuxAOut);
      if (RF_RSel[2]) r2_q <= fun8(RF_FunSel, r2_q, MuxAOut);
      if (RF_RSel[1]) r3_q <= fun8(RF_FunSel, r3_q, MuxAOut);
      if (RF_RSel[0]) r4_q <= fun8(RF_FunSel, r4_q, MuxAOut);
      if (RF_TSel[3]) t1_q <= fun8(RF_FunSel, t1_q, MuxAOut);
      if (RF_TSel[2]) t2_q <= fun8(RF_FunSel, t2_q, MuxAOut);
      if (RF_TSel[1]) t3_q <= fun8(RF_FunSel, t3_q, MuxAOut);
      if (RF_TSel[0]) t4_q <= fun8(RF_FunSel, t4_q, MuxAOut);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q <= '0; ar_q <= '0; sp_q <= '0; pcpast_q <= '0;
    end else begin
      if (ARF_RegSel[3]) pc_q     <= fun8(ARF_FunSel, pc_q, MuxBOut);
      if (ARF_RegSel[2]) ar_q     <= fun8(ARF_FunSel, ar_q, MuxBOut);
      if (ARF_RegSel[1]) sp_q     <= fun8(ARF_FunSel, sp_q, MuxBOut);
      if (ARF_RegSel[0]) pcpast_q <= fun8(ARF_FunSel, pcpast_q, MuxBOut);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir_q <= '0;
    end else if (IR_Enable) begin
      case (IR_Funsel)
        2'b00: ir_q <= ir_q - 16'd1;
        2'b01: ir_q <= ir_q + 16'd1;
        2'b10: begin
          if (IR_LH) ir_q[15:8] <= MemoryOut;
          else       ir_q[7:0]  <= MemoryOut;
        end
        default: ir_q <= '0;
      endcase
    end
  end

  // Memory content is deliberately outside the reset domain.
  assign mem_rd = !Mem_CS && !Mem_WR;
  assign mem_wr = !Mem_CS && Mem_WR;

  always_ff @(posedge Clock) begin
    if (mem_wr) mem[Address] <= ALUOut;
  end

  assign MemoryOut = mem_rd ? mem[Address] : 8'h00;

  always_comb begin
    case (MuxASel)
      2'b00:   MuxAOut = ALUOut;
      2'b01:   MuxAOut = MemoryOut;
      2'b10:   MuxAOut = ir_q[7:0];
      default: MuxAOut = ARF_AOut;
    endcase
    case (MuxBSel)
      2'b00:   MuxBOut = ALUOut;
      2'b01:   MuxBOut = MemoryOut;
      2'b10:   MuxBOut = ir_q[7:0];
      default: MuxBOut = ARF_AOut;
    endcase
    MuxCOut = MuxCSel ? ARF_AOut : AOut;
  end

  assign alu_a = MuxCOut;
  assign alu_b = BOut;

  // flag_d starts from the held flags; each operation overrides only what it owns.
  always_comb begin
    flag_d  = flag_q;
    alu_res = '0;
    sum9    = '0;
    case (ALU_FunSel)
      4'b0000: alu_res = alu_a;
      4'b0001: alu_res = alu_b;
      4'b0010: alu_res = ~alu_a;
      4'b0011: alu_res = ~alu_b;
      4'b0100, 4'b0101: begin
        sum9 = {1'b0, alu_a} + {1'b0, alu_b} +
               {8'd0, (ALU_FunSel == 4'b0101) & flag_q[2]};
        alu_res   = sum9[7:0];
        flag_d[2] = sum9[8];
        flag_d[0] = (alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]);
      end
      4'b0110: begin
        alu_res   = alu_a - alu_b;
        flag_d[2] = alu_a < alu_b;
        flag_d[0] = (alu_a[7] != alu_b[7]) && (alu_res[7] != alu_a[7]);
      end
      4'b0111: alu_res = alu_a & alu_b;
      4'b1000: alu_res = alu_a | alu_b;
      4'b1001: alu_res = alu_a ^ alu_b;
      4'b1010: begin
        alu_res   = {alu_a[6:0], 1'b0};
        flag_d[2] = alu_a[7];
      end
      4'b1011: begin
        alu_res   = {1'b0, alu_a[7:1]};
        flag_d[2] = alu_a[0];
      end
      4'b1100: begin
        alu_res   = {alu_a[6:0], 1'b0};
        flag_d[0] = alu_a[7] ^ alu_a[6];
      end
      4'b1101: alu_res = {alu_a[7], alu_a[7:1]};
      4'b1110: begin
        alu_res   = {alu_a[6:0], flag_q[2]};
        flag_d[2] = alu_a[7];
      end
      default: begin
        alu_res   = {flag_q[2], alu_a[7:1]};
        flag_d[2] = alu_a[0];
      end
    endcase
    flag_d[3] = (alu_res == 8'd0);
    if (ALU_FunSel != 4'b1101) flag_d[1] = alu_res[7];
  end

  assign ALUOut = alu_res;

  always_ff @(posedge Clock) begin
    if (Reset) flag_q <= '0;
    else       flag_q <= flag_d;
  end

endmodule

// File: tb/tb_alu_system.sv
// Directed scenarios plus randomized control words, every cycle checked against
// an array-based reference of the whole datapath.
module tb_alu_system;

  logic        Clock, Reset;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic [3:0]  ALU_FunSel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [7:0]  AOut, BOut, ALUOut, ARF_AOut, Address, MemoryOut, MuxAOut, MuxBOut, MuxCOut;
  logic [3:0]  ALUOutFlag;
  logic [15:0] IROut;

  alu_system dut (
    .Clock(Clock), .Reset(Reset),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .ALU_FunSel(ALU_FunSel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .AOut(AOut), .BOut(BOut), .ALUOut(ALUOut), .ARF_AOut(ARF_AOut), .Address(Address),
    .MemoryOut(MemoryOut), .MuxAOut(MuxAOut), .MuxBOut(MuxBOut), .MuxCOut(MuxCOut),
    .ALUOutFlag(ALUOutFlag), .IROut(IROut)
  );

  // clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, finish required");
    $fatal(1);
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference state: rf index = select code (T1..T4, R1..R4), arf index = C/D code
  logic [7:0]  m_rf [8];
  logic [7:0]  m_arf [4];
  logic [15:0] m_ir;
  logic [7:0]  m_mem [256];
  logic [3:0]  m_flag;
  logic [7:0]  e_aout, e_bout, e_alu, e_arfa, e_addr, e_mem, e_muxa, e_muxb, e_muxc;
  logic [3:0]  e_flag;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_fun(input logic [1:0] f, input logic [7:0] v,
                                       input logic [7:0] d);
    int t;
    case (f)
      2'd0:    t = (int'(v) + 255) % 256;
      2'd1:    t = (int'(v) + 1) % 256;
      2'd2:    t = int'(d);
      default: t = 0;
    endcase
    return t[7:0];
  endfunction

  function automatic int as_signed(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  task automatic model_eval();
    logic [7:0] a, b, r;
    logic z, c, n, o, ci;
    int u, s, sa, sb;
    e_aout = m_rf[RF_OutASel];
    e_bout = m_rf[RF_OutBSel];
    e_arfa = m_arf[ARF_OutCSel];
    e_addr = m_arf[ARF_OutDSel];
    e_mem  = (!Mem_CS && !Mem_WR) ? m_mem[e_addr] : 8'h00;
    e_muxc = MuxCSel ? e_arfa : e_aout;
    a = e_muxc; b = e_bout; ci = m_flag[2];
    {z, c, n, o} = m_flag;
    sa = as_signed(a); sb = as_signed(b);
    u = 0; s = 0; r = 8'h00;
    case (ALU_FunSel)
      4'd0: r = a;
      4'd1: r = b;
      4'd2: r = ~a;
      4'd3: r = ~b;
      4'd4, 4'd5: begin
        u = int'(a) + int'(b) + ((ALU_FunSel == 4'd5) ? int'(ci) : 0);
        s = sa + sb + ((ALU_FunSel == 4'd5) ? int'(ci) : 0);
        r = u[7:0]; c = (u > 255); o = (s > 127) || (s < -128);
      end
      4'd6: begin
        u = int'(a) - int'(b); s = sa - sb;
        r = u[7:0]; c = (a < b); o = (s > 127) || (s < -128);
      end
      4'd7: r = a & b;
      4'd8: r = a | b;
      4'd9: r = a ^ b;
      4'd10: begin u = int'(a) * 2; r = u[7:0]; c = (u > 255); end
      4'd11: begin u = int'(a) / 2; r = u[7:0]; c = (int'(a) % 2 == 1); end
      4'd12: begin
        u = int'(a) * 2; s = sa * 2;
        r = u[7:0]; o = (s > 127) || (s < -128);
      end
      4'd13: begin s = (sa < 0) ? (sa - 1) / 2 : sa / 2; r = s[7:0]; end
      4'd14: begin u = int'(a) * 2 + int'(ci); r = u[7:0]; c = (u > 255); end
      default: begin
        u = int'(a) + 256 * int'(ci); s = u / 2;
        r = s[7:0]; c = (u % 2 == 1);
      end
    endcase
    z = (r == 8'h00);
    if (ALU_FunSel != 4'd13) n = (r >= 8'd128);
    e_alu = r;
    e_flag = {z, c, n, o};
    case (MuxASel)
      2'd0: e_muxa = e_alu;
      2'd1: e_muxa = e_mem;
      2'd2: e_muxa = m_ir[7:0];
      default: e_muxa = e_arfa;
    endcase
    case (MuxBSel)
      2'd0: e_muxb = e_alu;
      2'd1: e_muxb = e_mem;
      2'd2: e_muxb = m_ir[7:0];
      default: e_muxb = e_arfa;
    endcase
  endtask

  task automatic model_clock();
    if (!Mem_CS && Mem_WR) m_mem[e_addr] = e_alu;
    if (Reset) begin
      foreach (m_rf[i]) m_rf[i] = 8'h00;
      foreach (m_arf[i]) m_arf[i] = 8'h00;
      m_ir = 16'h0000;
      m_flag = 4'h0;
    end else begin
      if (RF_RSel[3]) m_rf[4] = m_fun(RF_FunSel, m_rf[4], e_muxa);
      if (RF_RSel[2]) m_rf[5] = m_fun(RF_FunSel, m_rf[5], e_muxa);
      if (RF_RSel[1]) m_rf[6] = m_fun(RF_FunSel, m_rf[6], e_muxa);
      if (RF_RSel[0]) m_rf[7] = m_fun(RF_FunSel, m_rf[7], e_muxa);
      if (RF_TSel[3]) m_rf[0] = m_fun(RF_FunSel, m_rf[0], e_muxa);
      if (RF_TSel[2]) m_rf[1] = m_fun(RF_FunSel, m_rf[1], e_muxa);
      if (RF_TSel[1]) m_rf[2] = m_fun(RF_FunSel, m_rf[2], e_muxa);
      if (RF_TSel[0]) m_rf[3] = m_fun(RF_FunSel, m_rf[3], e_muxa);
      if (ARF_RegSel[3]) m_arf[3] = m_fun(ARF_FunSel, m_arf[3], e_muxb);
      if (ARF_RegSel[2]) m_arf[0] = m_fun(ARF_FunSel, m_arf[0], e_muxb);
      if (ARF_RegSel[1]) m_arf[1] = m_fun(ARF_FunSel, m_arf[1], e_muxb);
      if (ARF_RegSel[0]) m_arf[2] = m_fun(ARF_FunSel, m_arf[2], e_muxb);
      if (IR_Enable) begin
        case (IR_Funsel)
          2'd0: m_ir = 16'((int'(m_ir) + 65535) % 65536);
          2'd1: m_ir = 16'((int'(m_ir) + 1) % 65536);
          2'd2: m_ir = IR_LH ? {e_mem, m_ir[7:0]} : {m_ir[15:8], e_mem};
          default: m_ir = 16'h0000;
        endcase
      end
      m_flag = e_flag;
    end
  endtask

  // driver tasks
  task automatic idle();
    Reset = 1'b0;
    RF_OutASel = '0; RF_OutBSel = '0; RF_FunSel = '0; RF_RSel = '0; RF_TSel = '0;
    ARF_OutCSel = '0; ARF_OutDSel = '0; ARF_FunSel = '0; ARF_RegSel = '0;
    IR_LH = 1'b0; IR_Enable = 1'b0; IR_Funsel = '0;
    ALU_FunSel = '0; Mem_WR = 1'b0; Mem_CS = 1'b1;
    MuxASel = '0; MuxBSel = '0; MuxCSel = 1'b0;
  endtask

  // inputs are already driven after a falling edge; scoreboard compare, then clock
  task automatic cycle();
    #1;
    model_eval();
    chk("AOut", AOut, e_aout);
    chk("BOut", BOut, e_bout);
    chk("ALUOut", ALUOut, e_alu);
    chk("ARF_AOut", ARF_AOut, e_arfa);
    chk("Address", Address, e_addr);
    chk("MemoryOut", MemoryOut, e_mem);
    chk("MuxAOut", MuxAOut, e_muxa);
    chk("MuxBOut", MuxBOut, e_muxb);
    chk("MuxCOut", MuxCOut, e_muxc);
    chk("ALUOutFlag", ALUOutFlag, m_flag);
    chk("IROut", IROut, m_ir);
    @(posedge Clock);
    model_clock();
    @(negedge Clock);
  endtask

  // T1 <- v, built MSB first with shift-left and increment
  task automatic build_t1(input logic [7:0] v);
    logic [7:0] s;
    s = v;
    idle(); RF_FunSel = 2'b11; RF_TSel = 4'b1000; cycle();
    for (int i = 0; i < 8; i++) begin
      idle(); ALU_FunSel = 4'b1010; MuxASel = 2'b00; RF_FunSel = 2'b10; RF_TSel = 4'b1000;
      cycle();
      if (s[7]) begin
        idle(); RF_FunSel = 2'b01; RF_TSel = 4'b1000; cycle();
      end
      s = s << 1;
    end
  endtask

  task automatic copy_t1(input logic [3:0] rsel);
    idle(); ALU_FunSel = 4'b0000; MuxASel = 2'b00; RF_FunSel = 2'b10; RF_RSel = rsel;
    cycle();
  endtask

  task automatic store_t1(input logic [1:0] dsel);
    idle(); ALU_FunSel = 4'b0000; ARF_OutDSel = dsel; Mem_CS = 1'b0; Mem_WR = 1'b1;
    cycle();
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    foreach (m_rf[i]) m_rf[i] = 8'h00;
    foreach (m_arf[i]) m_arf[i] = 8'h00;
    m_ir = 16'h0000; m_flag = 4'h0;

    // reset: no comparison before the first edge, the DUT state is unknown
    idle(); Reset = 1'b1;
    @(posedge Clock);
    model_clock();
    @(negedge Clock);

    idle(); #1;
    chk("rst_AOut", AOut, 16'h0);
    chk("rst_BOut", BOut, 16'h0);
    chk("rst_ARF_AOut", ARF_AOut, 16'h0);
    chk("rst_Address", Address, 16'h0);
    chk("rst_IROut", IROut, 16'h0);
    chk("rst_flags", ALUOutFlag, 16'h0);
    cycle();

    // write zeros through every address (SP walks 0..255 and wraps)
    for (int i = 0; i < 256; i++) begin
      idle(); ARF_OutDSel = 2'b01; Mem_CS = 1'b0; Mem_WR = 1'b1;
      ARF_FunSel = 2'b01; ARF_RegSel = 4'b0010;
      cycle();
    end
    idle(); ARF_OutCSel = 2'b01; #1;
    chk("sp_wrap", ARF_AOut, 16'h00);
    cycle();

    // load R1 from memory at AR=0
    build_t1(8'h15);
    store_t1(2'b00);
    idle(); Mem_CS = 1'b0; ARF_OutDSel = 2'b00; MuxASel = 2'b01;
    RF_FunSel = 2'b10; RF_RSel = 4'b1000; #1;
    chk("mem0_read", MemoryOut, 16'h15);
    cycle();
    idle(); RF_OutASel = 3'b100; #1;
    chk("r1_load", AOut, 16'h15);
    chk("mem_inactive", MemoryOut, 16'h00);
    cycle();

    // add with signed overflow
    build_t1(8'h7F); copy_t1(4'b1000);
    build_t1(8'h01); copy_t1(4'b0100);
    idle(); RF_OutASel = 3'b100; RF_OutBSel = 3'b101; ALU_FunSel = 4'b0100; #1;
    chk("add_result", ALUOut, 16'h80);
    cycle();
    idle(); #1;
    chk("add_flags", ALUOutFlag, 16'b0011);
    cycle();

    // IR high then low byte
    build_t1(8'hAB); store_t1(2'b00);
    idle(); Mem_CS = 1'b0; IR_Enable = 1'b1; IR_Funsel = 2'b10; IR_LH = 1'b1; cycle();
    build_t1(8'hCD); store_t1(2'b00);
    idle(); Mem_CS = 1'b0; IR_Enable = 1'b1; IR_Funsel = 2'b10; IR_LH = 1'b0; cycle();
    idle(); #1;
    chk("ir_load", IROut, 16'hABCD);
    cycle();

    // memory write at SP=0x10 then read back
    build_t1(8'h10);
    idle(); MuxBSel = 2'b00; ARF_FunSel = 2'b10; ARF_RegSel = 4'b0010; cycle();
    build_t1(8'h5A); copy_t1(4'b1000);
    idle(); RF_OutASel = 3'b100; ARF_OutDSel = 2'b01; Mem_CS = 1'b0; Mem_WR = 1'b1; #1;
    chk("wr_alu", ALUOut, 16'h5A);
    chk("wr_addr", Address, 16'h10);
    cycle();
    idle(); ARF_OutDSel = 2'b01; Mem_CS = 1'b0; #1;
    chk("mem_readback", MemoryOut, 16'h5A);
    cycle();

    // PC wrap both ways
    build_t1(8'hFF);
    idle(); MuxBSel = 2'b00; ARF_FunSel = 2'b10; ARF_RegSel = 4'b1000; cycle();
    idle(); ARF_OutCSel = 2'b11; ARF_FunSel = 2'b01; ARF_RegSel = 4'b1000; #1;
    chk("pc_ff", ARF_AOut, 16'hFF);
    cycle();
    idle(); ARF_OutCSel = 2'b11; ARF_FunSel = 2'b00; ARF_RegSel = 4'b1000; #1;
    chk("pc_inc_wrap", ARF_AOut, 16'h00);
    cycle();
    idle(); ARF_OutCSel = 2'b11; #1;
    chk("pc_dec_wrap", ARF_AOut, 16'hFF);
    cycle();

    // reset wins over increments everywhere
    idle(); Reset = 1'b1; RF_FunSel = 2'b01; RF_RSel = 4'hF; RF_TSel = 4'hF;
    ARF_FunSel = 2'b01; ARF_RegSel = 4'hF; IR_Enable = 1'b1; IR_Funsel = 2'b01;
    ALU_FunSel = 4'b0010;
    cycle();
    idle(); #1;
    chk("rst2_flags", ALUOutFlag, 16'h0);
    chk("rst2_ir", IROut, 16'h0);
    for (int i = 0; i < 8; i++) begin
      idle(); RF_OutASel = 3'(i); RF_OutBSel = 3'(7 - i);
      ARF_OutCSel = 2'(i); ARF_OutDSel = 2'(i + 1); #1;
      chk("rst2_a", AOut, 16'h0);
      chk("rst2_b", BOut, 16'h0);
      chk("rst2_arf", ARF_AOut, 16'h0);
      chk("rst2_addr", Address, 16'h0);
      cycle();
    end
    idle(); Mem_CS = 1'b0; ARF_OutDSel = 2'b00; #1;
    chk("mem_kept", MemoryOut, 16'hCD);
    cycle();

    // randomized control words
    for (int k = 0; k < 800; k++) begin
      Reset       = ($urandom_range(0, 63) == 0);
      RF_OutASel  = 3'($urandom_range(0, 7));
      RF_OutBSel  = 3'($urandom_range(0, 7));
      RF_FunSel   = 2'($urandom_range(0, 3));
      RF_RSel     = 4'($urandom_range(0, 15));
      RF_TSel     = 4'($urandom_range(0, 15));
      ARF_OutCSel = 2'($urandom_range(0, 3));
      ARF_OutDSel = 2'($urandom_range(0, 3));
      ARF_FunSel  = 2'($urandom_range(0, 3));
      ARF_RegSel  = 4'($urandom_range(0, 15));
      IR_LH       = 1'($urandom_range(0, 1));
      IR_Enable   = 1'($urandom_range(0, 1));
      IR_Funsel   = 2'($urandom_range(0, 3));
      ALU_FunSel  = 4'($urandom_range(0, 15));
      Mem_CS      = 1'($urandom_range(0, 1));
      Mem_WR      = Reset ? 1'b0 : 1'($urandom_range(0, 1));
      MuxASel     = 2'($urandom_range(0, 3));
      MuxBSel     = 2'($urandom_range(0, 3));
      MuxCSel     = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
